// File: rtl/key_pkg.sv
// Shared defaults and helpers for the key synchroniser/debouncer.
package key_pkg;

  localparam int KEY_SYNC_STAGES_DEF   = 2;
  localparam int KEY_STABLE_CYCLES_DEF = 4;

  // A one-cycle stability window still needs a 1-bit counter.
  function automatic int key_cnt_width(input int stableCycles);
    return (stableCycles <= 2) ? 1 : $clog2(stableCycles);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: metastability synchroniser, stability counter, debounced level,
// registered rise/fall pulses and press-to-flip toggle.
module key_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES   = KEY_SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = KEY_STABLE_CYCLES_DEF,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int CW = key_cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncChain;
  logic [CW-1:0]          stableCnt;
  logic                   syncOut;

  assign syncOut = syncChain[SYNC_STAGES-1];

  // The level only moves after syncOut disagrees with it for STABLE_CYCLES
  // consecutive edges; any agreement in between restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncChain <= {SYNC_STAGES{RESET_LEVEL}};
      level     <= RESET_LEVEL;
      stableCnt <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      toggle    <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], key};
      rise      <= 1'b0;
      fall      <= 1'b0;
      if (syncOut == level) begin
        stableCnt <= '0;
      end else if (stableCnt == LAST) begin
        level     <= syncOut;
        stableCnt <= '0;
        rise      <= syncOut;
        fall      <= ~syncOut;
        if (syncOut) begin
          toggle <= ~toggle;
        end
      end else begin
        stableCnt <= stableCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_sync_debounce.sv
// CHANNELS independent debounced keys plus a combined event flag for
// downstream control logic.
module key_sync_debounce
  import key_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = KEY_SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = KEY_STABLE_CYCLES_DEF,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_rise,
  output logic [CHANNELS-1:0] key_fall,
  output logic [CHANNELS-1:0] key_toggle,
  output logic                any_event
);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_param_check
    $error("key_sync_debounce: need CHANNELS>=1, SYNC_STAGES>=2, STABLE_CYCLES>=1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    key_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .key   (key[i]),
      .level (key_level[i]),
      .rise  (key_rise[i]),
      .fall  (key_fall[i]),
      .toggle(key_toggle[i])
    );
  end

  assign any_event = |(key_rise | key_fall);

endmodule

// File: tb/tb_key_sync_debounce.sv
// Directed plus randomized bench for key_sync_debounce, checked every cycle
// against a window-based reference model.
module tb_key_sync_debounce;

  localparam int   CH     = 4;
  localparam int   SYNC   = 2;
  localparam int   STABLE = 4;
  localparam logic RL     = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] key;
  logic [CH-1:0] key_level, key_rise, key_fall, key_toggle;
  logic          any_event;

  int errors = 0;
  int checks = 0;

  // Model: keyQ delays raw keys by SYNC edges, syncQ keeps the last STABLE
  // synchronised samples since reset.
  logic [CH-1:0] keyQ[$];
  logic [CH-1:0] syncQ[$];
  logic [CH-1:0] mLevel, mRise, mFall, mToggle;

  always #5 clk = ~clk;

  key_sync_debounce #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .RESET_LEVEL  (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_level (key_level),
    .key_rise  (key_rise),
    .key_fall  (key_fall),
    .key_toggle(key_toggle),
    .any_event (any_event)
  );

  task automatic modelEdge(input logic [CH-1:0] k, input logic r);
    logic [CH-1:0] syncNow;
    logic [CH-1:0] newLevel;
    bit            allDiff;
    if (r) begin
      keyQ.delete();
      for (int i = 0; i < SYNC; i++) keyQ.push_back({CH{RL}});
      syncQ.delete();
      mLevel  = {CH{RL}};
      mRise   = '0;
      mFall   = '0;
      mToggle = '0;
    end else begin
      syncNow = keyQ[0];
      keyQ.push_back(k);
      void'(keyQ.pop_front());
      syncQ.push_back(syncNow);
      if (syncQ.size() > STABLE) void'(syncQ.pop_front());
      newLevel = mLevel;
      if (syncQ.size() == STABLE) begin
        for (int i = 0; i < CH; i++) begin
          allDiff = 1'b1;
          for (int j = 0; j < STABLE; j++)
            if (syncQ[j][i] == mLevel[i]) allDiff = 1'b0;
          if (allDiff) newLevel[i] = ~mLevel[i];
        end
      end
      mRise   = newLevel & ~mLevel;
      mFall   = ~newLevel & mLevel;
      mToggle = mToggle ^ mRise;
      mLevel  = newLevel;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("key_level",  32'(key_level),  32'(mLevel));
    checkValue("key_rise",   32'(key_rise),   32'(mRise));
    checkValue("key_fall",   32'(key_fall),   32'(mFall));
    checkValue("key_toggle", 32'(key_toggle), 32'(mToggle));
    checkValue("any_event",  32'(any_event),  32'(|(mRise | mFall)));
  endtask

  task automatic applyStimulus(input logic [CH-1:0] k, input logic r);
    @(negedge clk);
    key = k;
    rst = r;
    @(posedge clk);
    modelEdge(k, r);
    #1;
    checkOutput();
  endtask

  initial begin
    int riseAt;
    int riseCnt;
    int fallCnt;
    int anyCnt;
    bit sawBoth;
    logic [CH-1:0] rk;
    logic rr;

    key = '0;
    rst = 1'b1;
    modelEdge('0, 1'b1);

    // Reset with all keys held high, then full-latency acceptance.
    $display("[TB] reset with keys high");
    repeat (3) applyStimulus(4'b1111, 1'b1);
    checkValue("reset_level_zero", 32'(key_level), 32'h0);
    riseAt = 0;
    riseCnt = 0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'b1111, 1'b0);
      if (key_rise != 0) riseCnt++;
      if (key_rise == 4'b1111 && any_event && riseAt == 0) riseAt = i;
    end
    checkValue("post_reset_rise_edge", 32'(riseAt), 32'd6);
    checkValue("post_reset_rise_cycles", 32'(riseCnt), 32'd1);

    // Clean press on key[0].
    $display("[TB] clean press");
    repeat (2) applyStimulus(4'b0000, 1'b1);
    repeat (2) applyStimulus(4'b0000, 1'b0);
    riseAt = 0;
    riseCnt = 0;
    fallCnt = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(4'b0001, 1'b0);
      if (key_rise[0]) begin
        riseCnt++;
        if (riseAt == 0) riseAt = i;
      end
      if (key_fall != 0) fallCnt++;
    end
    checkValue("press_rise_edge", 32'(riseAt), 32'd6);
    checkValue("press_rise_count", 32'(riseCnt), 32'd1);
    checkValue("press_fall_count", 32'(fallCnt), 32'd0);
    checkValue("press_level0", 32'(key_level[0]), 32'd1);
    checkValue("press_toggle0", 32'(key_toggle[0]), 32'd1);

    // Glitch filter on key[1]: 3 cycles rejected, 4 cycles accepted.
    $display("[TB] glitch filter");
    repeat (3) applyStimulus(4'b0011, 1'b0);
    riseCnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0001, 1'b0);
      if (key_rise[1] || key_fall[1]) riseCnt++;
    end
    checkValue("glitch_no_event", 32'(riseCnt), 32'd0);
    checkValue("glitch_level1", 32'(key_level[1]), 32'd0);
    riseCnt = 0;
    fallCnt = 0;
    repeat (4) begin
      applyStimulus(4'b0011, 1'b0);
      if (key_rise[1]) riseCnt++;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0001, 1'b0);
      if (key_rise[1]) riseCnt++;
      if (key_fall[1]) fallCnt++;
    end
    checkValue("four_cycle_rise1", 32'(riseCnt), 32'd1);
    checkValue("four_cycle_fall1", 32'(fallCnt), 32'd1);

    // Simultaneous rise and fall on different channels.
    $display("[TB] simultaneous events");
    anyCnt = 0;
    sawBoth = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1100, 1'b0);
      if (any_event) anyCnt++;
      if (key_rise == 4'b1100 && key_fall == 4'b0001) sawBoth = 1'b1;
    end
    checkValue("simul_same_cycle", 32'(sawBoth), 32'd1);
    checkValue("simul_any_cycles", 32'(anyCnt), 32'd1);

    // Reset landing mid-count on key[2].
    $display("[TB] reset mid-count");
    applyStimulus(4'b0000, 1'b1);
    repeat (6) applyStimulus(4'b0000, 1'b0);
    riseCnt = 0;
    repeat (4) begin
      applyStimulus(4'b0100, 1'b0);
      if (key_rise != 0) riseCnt++;
    end
    applyStimulus(4'b0100, 1'b1);
    checkValue("midcount_no_pulse", 32'(riseCnt), 32'd0);
    riseAt = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(4'b0100, 1'b0);
      if (key_rise[2] && riseAt == 0) riseAt = i;
    end
    checkValue("midcount_rise_edge", 32'(riseAt), 32'd6);

    // Two press/release cycles on key[3].
    $display("[TB] toggle");
    riseCnt = 0;
    fallCnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        applyStimulus((i < 8) ? 4'b1100 : 4'b0100, 1'b0);
        if (key_rise[3]) riseCnt++;
        if (key_fall[3]) fallCnt++;
      end
      checkValue("toggle3_after_cycle", 32'(key_toggle[3]), (p == 0) ? 32'd1 : 32'd0);
    end
    checkValue("toggle3_rises", 32'(riseCnt), 32'd2);
    checkValue("toggle3_falls", 32'(fallCnt), 32'd2);

    // Random bouncing keys with occasional resets.
    $display("[TB] random phase");
    rk = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 4) == 0) rk[i] = ~rk[i];
      rr = ($urandom_range(0, 99) == 0);
      applyStimulus(rk, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_sync_debounce.md
Name: key_sync_debounce

Overview:
- Parametrised successor to the single-bit sampled key register.
- Takes CHANNELS asynchronous push-button/switch inputs and synchronises each through a flip-flop chain.
- Debounces each channel with a per-channel stability counter.
- Produces a clean level, single-cycle rise/fall pulses and a per-channel toggle (press-to-flip) state.
- Sits between board key pins and all downstream control logic.

Parameters:
- CHANNELS, 4: number of independent key inputs (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- STABLE_CYCLES, 4: consecutive cycles the synchronised input must differ from the accepted level before it is accepted (>=1).
- RESET_LEVEL, 0: reset value of synchroniser flops and key_level (1 for active-low keys).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- key  input  CHANNELS  raw asynchronous key inputs
- key_level  output  CHANNELS  debounced level
- key_rise  output  CHANNELS  one-cycle pulse when key_level goes 0->1
- key_fall  output  CHANNELS  one-cycle pulse when key_level goes 1->0
- key_toggle  output  CHANNELS  flips on every accepted rise
- any_event  output  1  OR of all key_rise|key_fall bits, same cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: sync chain = RESET_LEVEL, key_level = RESET_LEVEL, counters = 0, key_rise/key_fall/any_event = 0, key_toggle = 0.
- rst has priority over all other updates, including a mid-count or a same-cycle acceptance.
- Per channel:
  - s[0] <= key[i]; s[k] <= s[k-1]; sync_out = s[SYNC_STAGES-1].
  - If sync_out == key_level: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: key_level <= sync_out, cnt <= 0, pulse asserted.
  - Else: cnt <= cnt+1.
- Counter width: $clog2(STABLE_CYCLES) with a minimum of 1. The counter never exceeds STABLE_CYCLES-1; no wrap.
- Pulses:
  - key_rise/key_fall are registered and high for exactly the one cycle following the edge at which key_level changed, i.e. the same cycle key_level first shows the new value.
  - Both pulses are 0 in every other cycle.
  - A rise and a fall on the same channel are never high together.
- key_toggle[i] flips on the same edge that sets key_rise[i]; a fall has no effect on it.
- any_event is combinational OR of the registered pulses.
- Latency: key change sampled at edge k becomes visible on key_level after edge k+SYNC_STAGES+STABLE_CYCLES-1, i.e. SYNC_STAGES+STABLE_CYCLES edges (6 with defaults).
- Glitch rejection: a sync_out deviation lasting fewer than STABLE_CYCLES cycles resets the counter and produces no output change.
- STABLE_CYCLES=1: a change is accepted on the first mismatching cycle.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Release of reset with key != RESET_LEVEL is treated as a normal change: accepted after full latency, with a pulse.
- Elaboration $error if SYNC_STAGES<2, STABLE_CYCLES<1 or CHANNELS<1.

Decomposition:
- Package key_pkg holds:
  - default constants: KEY_SYNC_STAGES_DEF=2, KEY_STABLE_CYCLES_DEF=4.
  - the counter-width function (clog2, min 1).
- Sub-module key_channel implements one channel: sync chain, counter, level, pulses, toggle.
- Top generates CHANNELS instances and the any_event OR.

Test Plan (defaults, CHANNELS=4, SYNC=2, STABLE=4):
1. Reset: rst=1 for 3 cycles with key=4'b1111 -> all outputs 0 during reset. After release, key_level=4'b1111 and key_rise=4'b1111 appear together 6 edges after the first post-reset edge, for one cycle; any_event=1 that cycle.
2. Clean press: key[0] 0->1 held 10 cycles -> key_rise[0] high for exactly 1 cycle, 6 edges after the sampling edge. key_level[0]=1 and key_toggle[0]=1 thereafter; key_fall stays 0.
3. Glitch filter: key[1] high for 3 cycles -> no change on any output. key[1] high for 4 cycles -> key_level[1]=1 with one key_rise[1] pulse, then a key_fall[1] pulse after release.
4. Simultaneous: from key_level=4'b0001, apply key=4'b1100 in one cycle -> key_rise=4'b1100 and key_fall=4'b0001 in the same cycle, any_event=1 for exactly 1 cycle.
5. Reset mid-count: key[2] rises, rst pulsed once when cnt=2 -> no pulse. Counting restarts after reset release and acceptance occurs a full 6 edges after the first post-reset edge.
6. Toggle: two full press/release cycles on key[3] -> key_toggle[3] goes 0->1->0. Falls do not change it; two key_rise[3] and two key_fall[3] pulses observed.
